// File: rtl/vga_sync_timing.sv
// vga_sync_timing: VGA raster timing generator, advanced by rising edges of PixelClock sampled in the Clock domain
// Ports:
//   i_Clock       system clock (the only clock in this block)
//   i_Reset       synchronous, active-high reset
//   i_PixelClock  divided pixel clock, used only as a data input
//   o_HSync       horizontal sync, registered, asserted level = SyncActive
//   o_VSync       vertical sync, registered, asserted level = SyncActive
//   o_VideoOn     1 while (PixelX, PixelY) is inside the visible area, registered
//   o_PixelX      horizontal counter, 0 .. HTotal-1
//   o_PixelY      vertical counter, 0 .. VTotal-1
//   o_LineStart   one-Clock pulse when PixelX wraps to 0
//   o_FrameStart  one-Clock pulse when PixelX and PixelY both wrap to 0
//   o_PixelTick   combinational rising-edge detect of PixelClock
module vga_sync_timing #(
   parameter int   HVisible   = 640,
   parameter int   HFront     = 16,
   parameter int   HSyncW     = 96,
   parameter int   HBack      = 48,
   parameter int   VVisible   = 480,
   parameter int   VFront     = 10,
   parameter int   VSyncW     = 2,
   parameter int   VBack      = 33,
   parameter logic SyncActive = 1'b0
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_PixelClock,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic       o_VideoOn,
   output logic [9:0] o_PixelX,
   output logic [9:0] o_PixelY,
   output logic       o_LineStart,
   output logic       o_FrameStart,
   output logic       o_PixelTick
);
   typedef enum logic [1:0] {P_ACTIVE, P_FRONT, P_SYNC, P_BACK} phase_t;

   localparam int HTotal = HVisible + HFront + HSyncW + HBack;
   localparam int VTotal = VVisible + VFront + VSyncW + VBack;
   localparam logic [9:0] HLast = 10'(HTotal - 1);
   localparam logic [9:0] VLast = 10'(VTotal - 1);
   // Phase boundaries are 11 bits so a boundary equal to 1024 still compares correctly
   localparam logic [10:0] HActEnd = 11'(HVisible);
   localparam logic [10:0] HFrEnd  = 11'(HVisible + HFront);
   localparam logic [10:0] HSyEnd  = 11'(HVisible + HFront + HSyncW);
   localparam logic [10:0] VActEnd = 11'(VVisible);
   localparam logic [10:0] VFrEnd  = 11'(VVisible + VFront);
   localparam logic [10:0] VSyEnd  = 11'(VVisible + VFront + VSyncW);

   function automatic phase_t decode_phase(input logic [9:0] c, input logic [10:0] a, input logic [10:0] f, input logic [10:0] s);
      return ({1'b0, c} < a) ? P_ACTIVE : ({1'b0, c} < f) ? P_FRONT : ({1'b0, c} < s) ? P_SYNC : P_BACK;
   endfunction

   logic       r_PixelPrev;
   logic [9:0] r_PixelX, r_PixelY;
   logic       r_HSync, r_VSync, r_VideoOn, r_LineStart, r_FrameStart;
   logic       w_Tick, w_XEnd, w_YEnd;
   logic [9:0] w_NextX, w_NextY;
   phase_t     w_HPhase, w_VPhase;

   assign w_Tick   = i_PixelClock & ~r_PixelPrev;
   assign w_XEnd   = r_PixelX == HLast;
   assign w_YEnd   = r_PixelY == VLast;
   assign w_NextX  = !w_Tick ? r_PixelX : w_XEnd ? '0 : r_PixelX + 10'd1;
   assign w_NextY  = !(w_Tick && w_XEnd) ? r_PixelY : w_YEnd ? '0 : r_PixelY + 10'd1;
   // Outputs are decoded from the next counter values so they line up with the counters
   assign w_HPhase = decode_phase(w_NextX, HActEnd, HFrEnd, HSyEnd);
   assign w_VPhase = decode_phase(w_NextY, VActEnd, VFrEnd, VSyEnd);

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         r_PixelPrev  <= 1'b0;
         r_PixelX     <= '0;
         r_PixelY     <= '0;
         r_HSync      <= ~SyncActive;
         r_VSync      <= ~SyncActive;
         r_VideoOn    <= 1'b1;
         r_LineStart  <= 1'b0;
         r_FrameStart <= 1'b0;
      end else begin
         r_PixelPrev  <= i_PixelClock;
         r_PixelX     <= w_NextX;
         r_PixelY     <= w_NextY;
         r_HSync      <= (w_HPhase == P_SYNC) ? SyncActive : ~SyncActive;
         r_VSync      <= (w_VPhase == P_SYNC) ? SyncActive : ~SyncActive;
         r_VideoOn    <= (w_HPhase == P_ACTIVE) && (w_VPhase == P_ACTIVE);
         r_LineStart  <= w_Tick && w_XEnd;
         r_FrameStart <= w_Tick && w_XEnd && w_YEnd;
      end
   end

   assign o_HSync      = r_HSync;
   assign o_VSync      = r_VSync;
   assign o_VideoOn    = r_VideoOn;
   assign o_PixelX     = r_PixelX;
   assign o_PixelY     = r_PixelY;
   assign o_LineStart  = r_LineStart;
   assign o_FrameStart = r_FrameStart;
   assign o_PixelTick  = w_Tick;
endmodule
